// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: requester, memory and status signals of the shared
// 16-bit memory port. The slave modport is the arbiter's view; the master
// modport is the view of the requesters and memory macro around it.
interface mem_port_arbiter_if;
  logic        i_req;
  logic [15:0] i_addr;
  logic        i_done;
  logic [15:0] i_rdata;
  logic        d_req;
  logic        d_wr;
  logic [15:0] d_addr;
  logic [15:0] d_wdata;
  logic        d_done;
  logic [15:0] d_rdata;
  logic        mem_en;
  logic        mem_wr;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        busy;

  modport slave (
    input  i_req, i_addr, d_req, d_wr, d_addr, d_wdata, mem_rdata,
    output i_done, i_rdata, d_done, d_rdata,
    output mem_en, mem_wr, mem_addr, mem_wdata, busy
  );

  modport master (
    output i_req, i_addr, d_req, d_wr, d_addr, d_wdata, mem_rdata,
    input  i_done, i_rdata, d_done, d_rdata,
    input  mem_en, mem_wr, mem_addr, mem_wdata, busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one 16-bit memory port between instruction fetch
// and data load/store. One request is latched at a time, held on the memory
// for LAT cycles (legal 1..15), then a one-cycle done pulse goes to the owner.
// Optional feature: define MEM_ARB_ROUND_ROBIN_EN to alternate conflict
// grants; otherwise data has fixed priority.
module mem_port_arbiter #(
  parameter int unsigned LAT = 1
) (
  input  logic               clk,
  input  logic               rst,
  mem_port_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic [3:0]  cnt;
  logic        own_d;
  logic        wr_q;
  logic [15:0] addr_q;
  logic [15:0] wdata_q;
  logic [15:0] irdata_q;
  logic [15:0] drdata_q;
  logic        grant;
  logic        grant_d;

  assign grant = bus.i_req | bus.d_req;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic last_d;

  // Conflict goes to whoever did not own the previous grant
  always_comb begin
    grant_d = bus.d_req;
    if (bus.i_req && bus.d_req) begin
      grant_d = ~last_d;
    end
  end

  // Remember the owner of every grant; reset value means "instruction"
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_d <= 1'b0;
    end else if (state == IDLE && grant) begin
      last_d <= grant_d;
    end
  end
`else
  // Fixed priority: data always wins a conflict
  always_comb begin
    grant_d = bus.d_req;
  end
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next state and state-decoded outputs; mem_en drops with async reset
  // because it decodes the state register directly
  always_comb begin
    state_nx   = state;
    bus.mem_en = 1'b0;
    bus.mem_wr = 1'b0;
    bus.i_done = 1'b0;
    bus.d_done = 1'b0;
    bus.busy   = (state != IDLE);
    case (state)
      IDLE: begin
        if (grant) begin
          state_nx = ACCESS;
        end
      end
      ACCESS: begin
        bus.mem_en = 1'b1;
        bus.mem_wr = wr_q & own_d;
        if (cnt == '0) begin
          state_nx = DONE;
        end
      end
      DONE: begin
        bus.i_done = ~own_d;
        bus.d_done = own_d;
        state_nx   = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // Request latching, latency countdown and read-data capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      own_d    <= 1'b0;
      wr_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      irdata_q <= '0;
      drdata_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant) begin
            own_d  <= grant_d;
            wr_q   <= grant_d & bus.d_wr;
            addr_q <= grant_d ? bus.d_addr : bus.i_addr;
            cnt    <= 4'(LAT - 1);
            if (grant_d) begin
              wdata_q <= bus.d_wdata;
            end
          end
        end
        ACCESS: begin
          if (cnt != '0) begin
            cnt <= cnt - 4'd1;
          end else if (!wr_q) begin
            if (own_d) begin
              drdata_q <= bus.mem_rdata;
            end else begin
              irdata_q <= bus.mem_rdata;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.i_rdata   = irdata_q;
  assign bus.d_rdata   = drdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: two arbiters (LAT=1 and LAT=3) on a shared clock and
// reset. Stimulus pushes expected completions into per-DUT queues; a monitor
// per DUT tracks each memory access and checks it against the queue on done.
module tb_mem_port_arbiter;

  typedef struct {
    bit          own_d;
    logic [15:0] addr;
    bit          wr;
    logic [15:0] wdata;
    int          done_cyc;
    logic [15:0] irdata;
    logic [15:0] drdata;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;

  exp_t        q[2][$];
  logic [15:0] exp_ir[2];
  logic [15:0] exp_dr[2];

  mem_port_arbiter_if bus[2] ();

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s actual=%h expected=%h (t=%0t cyc=%0d)", nm, act, expv, $time, cyc);
    end
  endfunction

  // Bench memory: read data is a fixed function of the address
  function automatic logic [15:0] mem_of(logic [15:0] a);
    return a ^ 16'hBEFF;
  endfunction

  task automatic push(int g, bit d, logic [15:0] a, bit wr, logic [15:0] wd, int done_c);
    exp_t e;
    if (!wr) begin
      if (d) exp_dr[g] = mem_of(a);
      else   exp_ir[g] = mem_of(a);
    end
    e.own_d    = d;
    e.addr     = a;
    e.wr       = wr;
    e.wdata    = wd;
    e.done_cyc = done_c;
    e.irdata   = exp_ir[g];
    e.drdata   = exp_dr[g];
    q[g].push_back(e);
  endtask

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_until(int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int unsigned L = (g == 0) ? 1 : 3;

    mem_port_arbiter #(.LAT(L)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus[g])
    );

    assign bus[g].mem_rdata = bus[g].mem_en ? (bus[g].mem_addr ^ 16'hBEFF) : 16'h0000;

    logic        en_prev = 1'b0;
    int          en_cnt = 0;
    int          start_cyc = 0;
    logic [15:0] cap_addr = '0;
    logic [15:0] cap_wdata = '0;
    logic        cap_wr = 1'b0;
    logic        stable = 1'b1;

    always @(negedge clk) begin
      exp_t e;
      if (rst) begin
        en_prev = 1'b0;
      end else begin
        if (bus[g].mem_en) begin
          if (!en_prev) begin
            start_cyc = cyc;
            en_cnt    = 1;
            cap_addr  = bus[g].mem_addr;
            cap_wdata = bus[g].mem_wdata;
            cap_wr    = bus[g].mem_wr;
            stable    = 1'b1;
          end else begin
            en_cnt++;
            if (bus[g].mem_addr !== cap_addr || bus[g].mem_wdata !== cap_wdata ||
                bus[g].mem_wr !== cap_wr)
              stable = 1'b0;
          end
        end
        en_prev = bus[g].mem_en;
        if (bus[g].i_done || bus[g].d_done) begin
          if (q[g].size() == 0) begin
            chk($sformatf("dut%0d_unexpected_done", g), {bus[g].i_done, bus[g].d_done}, 0);
          end else begin
            e = q[g].pop_front();
            chk($sformatf("dut%0d_one_done", g), bus[g].i_done & bus[g].d_done, 0);
            chk($sformatf("dut%0d_owner", g), bus[g].d_done, e.own_d);
            chk($sformatf("dut%0d_done_cycle", g), cyc, e.done_cyc);
            chk($sformatf("dut%0d_en_start", g), start_cyc, e.done_cyc - int'(L));
            chk($sformatf("dut%0d_en_cycles", g), en_cnt, L);
            chk($sformatf("dut%0d_addr", g), cap_addr, e.addr);
            chk($sformatf("dut%0d_wr", g), cap_wr, e.wr);
            if (e.wr) chk($sformatf("dut%0d_wdata", g), cap_wdata, e.wdata);
            chk($sformatf("dut%0d_stable", g), stable, 1);
            chk($sformatf("dut%0d_en_wr_in_done", g), {bus[g].mem_en, bus[g].mem_wr}, 0);
            chk($sformatf("dut%0d_busy_done", g), bus[g].busy, 1);
            chk($sformatf("dut%0d_i_rdata", g), bus[g].i_rdata, e.irdata);
            chk($sformatf("dut%0d_d_rdata", g), bus[g].d_rdata, e.drdata);
          end
        end
      end
    end
  end

  task automatic chk_reset_outputs();
    chk("dut0_rst_flags", {bus[0].i_done, bus[0].d_done, bus[0].mem_en, bus[0].mem_wr, bus[0].busy}, 0);
    chk("dut0_rst_rdata", {bus[0].i_rdata, bus[0].d_rdata}, 0);
    chk("dut0_rst_mem", {bus[0].mem_addr, bus[0].mem_wdata}, 0);
    chk("dut1_rst_flags", {bus[1].i_done, bus[1].d_done, bus[1].mem_en, bus[1].mem_wr, bus[1].busy}, 0);
    chk("dut1_rst_rdata", {bus[1].i_rdata, bus[1].d_rdata}, 0);
    chk("dut1_rst_mem", {bus[1].mem_addr, bus[1].mem_wdata}, 0);
  endtask

  initial begin
    int t0;
    rst = 1'b1;
    bus[0].i_req = 1'b0; bus[0].i_addr = '0; bus[0].d_req = 1'b0;
    bus[0].d_wr  = 1'b0; bus[0].d_addr = '0; bus[0].d_wdata = '0;
    bus[1].i_req = 1'b0; bus[1].i_addr = '0; bus[1].d_req = 1'b0;
    bus[1].d_wr  = 1'b0; bus[1].d_addr = '0; bus[1].d_wdata = '0;
    exp_ir[0] = '0; exp_dr[0] = '0; exp_ir[1] = '0; exp_dr[1] = '0;
    tick(2);
    chk_reset_outputs();
    rst = 1'b0;
    tick(1);

    // Instruction read on LAT=1: done two cycles after the request cycle
    t0 = cyc;
    bus[0].i_addr = 16'h0010;
    bus[0].i_req  = 1'b1;
    push(0, 1'b0, 16'h0010, 1'b0, 16'h0000, t0 + 2);
    wait_until(t0 + 3);
    bus[0].i_req = 1'b0;
    tick(1);

    // LAT=3: data read so d_rdata is non-zero before the write
    t0 = cyc;
    bus[1].d_addr = 16'h0300;
    bus[1].d_wr   = 1'b0;
    bus[1].d_req  = 1'b1;
    push(1, 1'b1, 16'h0300, 1'b0, 16'h0000, t0 + 4);
    wait_until(t0 + 5);
    bus[1].d_req = 1'b0;
    tick(1);

    // LAT=3 write; instruction request arrives mid-access and must wait
    t0 = cyc;
    bus[1].d_addr  = 16'h0200;
    bus[1].d_wdata = 16'h1234;
    bus[1].d_wr    = 1'b1;
    bus[1].d_req   = 1'b1;
    push(1, 1'b1, 16'h0200, 1'b1, 16'h1234, t0 + 4);
    wait_until(t0 + 2);
    bus[1].i_addr = 16'h0040;
    bus[1].i_req  = 1'b1;
    push(1, 1'b0, 16'h0040, 1'b0, 16'h0000, t0 + 9);
    wait_until(t0 + 5);
    bus[1].d_req = 1'b0;
    bus[1].d_wr  = 1'b0;
    wait_until(t0 + 10);
    bus[1].i_req = 1'b0;
    tick(1);

    // Asynchronous reset in the middle of an access: no done, mem_en drops at once
    t0 = cyc;
    bus[1].d_addr = 16'h0500;
    bus[1].d_req  = 1'b1;
    wait_until(t0 + 2);
    chk("dut1_en_before_rst", bus[1].mem_en, 1);
    #2 rst = 1'b1;
    #1;
    chk("dut1_en_async_drop", {bus[1].mem_en, bus[1].busy, bus[1].d_done}, 0);
    chk_reset_outputs();
    exp_ir[0] = '0; exp_dr[0] = '0; exp_ir[1] = '0; exp_dr[1] = '0;
    bus[1].d_req = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    tick(6);

    // Conflict on LAT=1: data first, instruction after
    t0 = cyc;
    bus[0].i_addr = 16'h0010;
    bus[0].d_addr = 16'h0020;
    bus[0].d_wr   = 1'b0;
    bus[0].i_req  = 1'b1;
    bus[0].d_req  = 1'b1;
    push(0, 1'b1, 16'h0020, 1'b0, 16'h0000, t0 + 2);
    push(0, 1'b0, 16'h0010, 1'b0, 16'h0000, t0 + 5);
    wait_until(t0 + 3);
    bus[0].d_req = 1'b0;
    wait_until(t0 + 6);
    bus[0].i_req = 1'b0;
    tick(1);

    // Fresh reset, then both requesters held for four grants
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    exp_ir[0] = '0; exp_dr[0] = '0; exp_ir[1] = '0; exp_dr[1] = '0;
    tick(1);
    t0 = cyc;
    bus[0].i_req = 1'b1;
    bus[0].d_req = 1'b1;
    for (int k = 0; k < 4; k++) begin
      bit dk;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      dk = ((k % 2) == 0);
`else
      dk = 1'b1;
`endif
      push(0, dk, dk ? 16'h0020 : 16'h0010, 1'b0, 16'h0000, t0 + 2 + 3 * k);
    end
    wait_until(t0 + 12);
    bus[0].i_req = 1'b0;
    bus[0].d_req = 1'b0;
    tick(5);

    chk("dut0_queue_drained", q[0].size(), 0);
    chk("dut1_queue_drained", q[1].size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
